// File: rtl/jt51_pg_acc_if.sv
// Host readback bus of jt51_pg_acc: request/acknowledge handshake plus captured phase.
// master = host side, slave = accumulator side.
interface jt51_pg_acc_if #(
    parameter int SW  = 6,
    parameter int PHW = 20
);
    logic           rd_req;
    logic [SW-1:0]  rd_slot;
    logic           rd_ack;
    logic           rd_valid;
    logic           rd_err;
    logic [PHW-1:0] rd_data;

    modport master (
        output rd_req, rd_slot, rd_ack,
        input  rd_valid, rd_err, rd_data
    );

    modport slave (
        input  rd_req, rd_slot, rd_ack,
        output rd_valid, rd_err, rd_data
    );
endinterface

// File: rtl/jt51_pg_acc.sv
// Time-multiplexed JT51 phase accumulator: MUL stage, accumulate stage, SLOTS-deep circular phase store.
// Optional host readback FSM is built only when JT51_PG_READBACK_EN is defined.
module jt51_pg_acc #(
    parameter int SLOTS = 32,
    parameter int PHW   = 20,
    parameter int OUTW  = 10,
    parameter int SW    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            zero,
    input  logic [PHW-1:0]  base,
    input  logic [3:0]      mul,
    input  logic            pg_rst,
    output logic [OUTW-1:0] phase_out,
    output logic [SW-1:0]   phase_slot,
    jt51_pg_acc_if.slave    rd
);
    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

    // MUL=0 is the half-step case; other factors wrap at the accumulator width.
    function automatic logic [PHW-1:0] mul_step(input logic [PHW-1:0] b, input logic [3:0] m);
        logic [PHW-1:0] prod;
        prod = b * PHW'(m);
        return (m == 4'd0) ? (b >> 1) : prod;
    endfunction

    logic [PHW-1:0] step_p0;
    logic           clr_p0;
    logic [SW-1:0]  scnt;
    logic [PHW-1:0] acc_p1;
    logic [SW-1:0]  slot_p1;
    logic [PHW-1:0] ring [SLOTS-1];

    // Stage A: scnt is the slot index of the data held in this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_p0 <= '0;
            clr_p0  <= 1'b0;
            scnt    <= '0;
        end else if (cen) begin
            step_p0 <= mul_step(base, mul);
            clr_p0  <= pg_rst;
            scnt    <= (zero || scnt == LAST) ? '0 : scnt + 1'b1;
        end
    end

    // Stage B: acc_p1 plus SLOTS-1 ring entries give a SLOTS-cycle round trip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1  <= '0;
            slot_p1 <= '0;
            for (int i = 0; i < SLOTS - 1; i++) ring[i] <= '0;
        end else if (cen) begin
            acc_p1  <= clr_p0 ? '0 : ring[SLOTS-2] + step_p0;
            slot_p1 <= scnt;
            ring[0] <= acc_p1;
            for (int i = 1; i < SLOTS - 1; i++) ring[i] <= ring[i-1];
        end
    end

    assign phase_out  = acc_p1[PHW-1 -: OUTW];
    assign phase_slot = slot_p1;

`ifdef JT51_PG_READBACK_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE} rb_state_t;

    rb_state_t      rb_st;
    logic [SW-1:0]  rb_slot;
    logic           rb_valid;
    logic           rb_err;
    logic [PHW-1:0] rb_data;

    // The handshake itself is cen-independent; only the capture waits for a cen edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_st    <= IDLE;
            rb_slot  <= '0;
            rb_valid <= 1'b0;
            rb_err   <= 1'b0;
            rb_data  <= '0;
        end else begin
            case (rb_st)
                IDLE: begin
                    if (rd.rd_req) begin
                        if ({1'b0, rd.rd_slot} < (SW+1)'(SLOTS)) begin
                            rb_slot <= rd.rd_slot;
                            rb_st   <= WAIT;
                        end else begin
                            rb_err   <= 1'b1;
                            rb_data  <= '0;
                            rb_valid <= 1'b1;
                            rb_st    <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cen && slot_p1 == rb_slot) begin
                        rb_data  <= acc_p1;
                        rb_err   <= 1'b0;
                        rb_valid <= 1'b1;
                        rb_st    <= DONE;
                    end
                end
                DONE: begin
                    if (rd.rd_ack) begin
                        rb_valid <= 1'b0;
                        rb_st    <= IDLE;
                    end
                end
                default: rb_st <= IDLE;
            endcase
        end
    end

    assign rd.rd_valid = rb_valid;
    assign rd.rd_err   = rb_err;
    assign rd.rd_data  = rb_data;
`else
    logic unused_rd;
    assign unused_rd   = ^{rd.rd_req, rd.rd_slot, rd.rd_ack};
    assign rd.rd_valid = 1'b0;
    assign rd.rd_err   = 1'b0;
    assign rd.rd_data  = '0;
`endif
endmodule

// File: tb/tb_jt51_pg_acc.sv
// Bench for jt51_pg_acc: scoreboard of expected phases per slot, readback handshake,
// out-of-range request on a 24-slot instance and reset during a pending readback.
module tb_jt51_pg_acc;
    localparam int SLOTS = 32;
    localparam int PHW   = 20;
    localparam int OUTW  = 10;
    localparam int SW    = 6;

    typedef struct {
        int             slot;
        logic [PHW-1:0] acc;
        int             due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst, cen, zero, pg_rst;
    logic [PHW-1:0]  base;
    logic [3:0]      mul;
    logic [OUTW-1:0] phase_out;
    logic [SW-1:0]   phase_slot;
    logic [OUTW-1:0] unused_phase24;
    logic [SW-1:0]   unused_slot24;

    int n_chk = 0;
    int n_pass = 0;
    int ecnt = 0;
    int cur = 0;
    int pass = 0;
    int pg_slot = 7;
    int pg_pass = 4;
    int n;
    bit seen;
    logic [PHW-1:0] cap;

    logic [PHW-1:0] base_t [SLOTS];
    logic [3:0]     mul_t [SLOTS];
    logic [PHW-1:0] acc_m [SLOTS];
    logic [PHW-1:0] last_seen [SLOTS];
    exp_t           sbq [$];

    jt51_pg_acc_if #(.SW(SW), .PHW(PHW)) rif ();
    jt51_pg_acc_if #(.SW(SW), .PHW(PHW)) rif24 ();

    jt51_pg_acc #(.SLOTS(SLOTS), .PHW(PHW), .OUTW(OUTW), .SW(SW)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .base(base), .mul(mul),
        .pg_rst(pg_rst), .phase_out(phase_out), .phase_slot(phase_slot), .rd(rif.slave)
    );

    jt51_pg_acc #(.SLOTS(24), .PHW(PHW), .OUTW(OUTW), .SW(SW)) u_dut24 (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .base(base), .mul(mul),
        .pg_rst(pg_rst), .phase_out(unused_phase24), .phase_slot(unused_slot24), .rd(rif24.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cen && !rst) ecnt <= ecnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one slot, predict its phase two cen edges ahead, retire due predictions.
    task automatic cycle();
        exp_t           e;
        logic [PHW-1:0] st;
        int             s;
        s      = cur;
        zero   = (s == 0);
        base   = base_t[s];
        mul    = mul_t[s];
        pg_rst = (s == pg_slot) && (pass == pg_pass);
        cen    = 1'b1;
        st = (mul_t[s] == 4'd0) ? (base_t[s] >> 1) : base_t[s] * {16'd0, mul_t[s]};
        acc_m[s] = pg_rst ? '0 : acc_m[s] + st;
        e.slot = s;
        e.acc  = acc_m[s];
        e.due  = ecnt + 2;
        sbq.push_back(e);
        if (s == SLOTS - 1) begin
            cur = 0;
            pass++;
        end else begin
            cur = s + 1;
        end
        @(posedge clk);
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].due <= ecnt) begin
            e = sbq.pop_front();
            chk("phase_slot", 32'(phase_slot), e.slot);
            chk("phase_out", 32'(phase_out), 32'(e.acc[PHW-1 -: OUTW]));
            last_seen[e.slot] = e.acc;
        end
    endtask

    task automatic idle_clk(input int k);
        cen = 1'b0;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase_out"}, 32'(phase_out), 0);
        chk({tag, "_phase_slot"}, 32'(phase_slot), 0);
        chk({tag, "_rd_valid"}, 32'(rif.rd_valid), 0);
        chk({tag, "_rd_err"}, 32'(rif.rd_err), 0);
        chk({tag, "_rd_data"}, 32'(rif.rd_data), 0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; zero = 1'b0; base = '0; mul = '0; pg_rst = 1'b0;
        rif.rd_req = 1'b0;   rif.rd_slot = '0;   rif.rd_ack = 1'b0;
        rif24.rd_req = 1'b0; rif24.rd_slot = '0; rif24.rd_ack = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            base_t[i] = '0; mul_t[i] = '0; acc_m[i] = '0; last_seen[i] = '0;
        end
        base_t[0] = 20'd100;   mul_t[0] = 4'd0;
        base_t[5] = 20'h10000; mul_t[5] = 4'd3;
        base_t[6] = 20'h0C345; mul_t[6] = 4'd1;
        base_t[7] = 20'h1F00F; mul_t[7] = 4'd0;
        base_t[8] = 20'h0ABCD; mul_t[8] = 4'd15;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Eight passes: half-step, wrap of slot 5 after pass 6, key-on of slot 7 on pass 4.
        repeat (8 * SLOTS) cycle();
        while (cur != 8) cycle();

`ifdef JT51_PG_READBACK_EN
        rif.rd_slot = 5; rif.rd_req = 1'b1; cycle(); rif.rd_req = 1'b0;
        cycle();
        rif.rd_slot = 9; rif.rd_req = 1'b1; cycle(); rif.rd_req = 1'b0;
        n = 2;
        while (rif.rd_valid !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk("rb_within_33_cen", 32'(n <= 33), 1);
        cap = last_seen[5];
        chk("rb_err", 32'(rif.rd_err), 0);
        chk("rb_data", 32'(rif.rd_data), 32'(cap));
        repeat (3) cycle();
        chk("rb_hold_valid", 32'(rif.rd_valid), 1);
        chk("rb_hold_data", 32'(rif.rd_data), 32'(cap));
        rif.rd_ack = 1'b1; cycle(); rif.rd_ack = 1'b0;
        chk("rb_ack_valid", 32'(rif.rd_valid), 0);
        seen = 1'b0;
        repeat (SLOTS + 2) begin
            cycle();
            if (rif.rd_valid) seen = 1'b1;
        end
        chk("rb_second_req_ignored", 32'(seen), 0);

        rif24.rd_slot = 30; rif24.rd_req = 1'b1; cycle(); rif24.rd_req = 1'b0;
        chk("oor_valid", 32'(rif24.rd_valid), 1);
        chk("oor_err", 32'(rif24.rd_err), 1);
        chk("oor_data", 32'(rif24.rd_data), 0);
        rif24.rd_ack = 1'b1; cycle(); rif24.rd_ack = 1'b0;
        chk("oor_ack_valid", 32'(rif24.rd_valid), 0);

        rif.rd_slot = 20; rif.rd_req = 1'b1; idle_clk(1); rif.rd_req = 1'b0;
        idle_clk(4);
        chk("wait_cen_low_valid", 32'(rif.rd_valid), 0);
`else
        rif.rd_slot = 5; rif.rd_req = 1'b1; cycle(); rif.rd_req = 1'b0;
        rif24.rd_slot = 30; rif24.rd_req = 1'b1; cycle(); rif24.rd_req = 1'b0;
        seen = 1'b0;
        repeat (SLOTS + 2) begin
            cycle();
            if (rif.rd_valid || rif.rd_err || (|rif.rd_data) ||
                rif24.rd_valid || rif24.rd_err || (|rif24.rd_data)) seen = 1'b1;
        end
        rif.rd_ack = 1'b1; cycle(); rif.rd_ack = 1'b0;
        chk("rd_tied_zero", 32'(seen), 0);
        rif.rd_slot = 20; rif.rd_req = 1'b1; idle_clk(1); rif.rd_req = 1'b0;
        idle_clk(4);
        chk("rd_valid_off", 32'(rif.rd_valid), 0);
`endif

        // Asynchronous reset while a readback is pending.
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < SLOTS; i++) acc_m[i] = '0;
        cur = 0;
        pass = 20;
        seen = 1'b0;
        repeat (2 * SLOTS) begin
            cycle();
            if (rif.rd_valid || rif.rd_err) seen = 1'b1;
        end
        chk("post_rst_idle", 32'(seen), 0);

`ifdef JT51_PG_READBACK_EN
        rif.rd_slot = 7; rif.rd_req = 1'b1; cycle(); rif.rd_req = 1'b0;
        n = 1;
        while (rif.rd_valid !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk("rb2_within_33_cen", 32'(n <= 33), 1);
        chk("rb2_data", 32'(rif.rd_data), 32'(last_seen[7]));
        rif.rd_ack = 1'b1; cycle(); rif.rd_ack = 1'b0;
        chk("rb2_ack_valid", 32'(rif.rd_valid), 0);
`else
        rif.rd_slot = 7; rif.rd_req = 1'b1; cycle(); rif.rd_req = 1'b0;
        repeat (SLOTS) cycle();
        chk("rd_data_off", 32'(rif.rd_data), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
